// File: rtl/lid_pkg.sv
// Shared lid controller encodings: FSM states, speed-mode codes and open direction.
package lid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FAULT   = 2'd3
  } lid_state_t;

  localparam logic       DIR_OPEN  = 1'b0;
  localparam logic [1:0] MODE_FAST = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;

  // Slow down once the remaining distance to the travel target is inside the slow zone.
  function automatic logic [1:0] speed_mode(input lid_state_t  st,
                                            input logic [15:0] pos,
                                            input logic [15:0] open_pos,
                                            input logic [15:0] slow_zone);
    logic [1:0] mode;
    mode = MODE_FAST;
    if (st == OPENING && (open_pos - pos) <= slow_zone)
      mode = MODE_SLOW;
    else if (st == CLOSING && pos <= slow_zone)
      mode = MODE_SLOW;
    return mode;
  endfunction

endpackage

// File: rtl/lid_step_detect.sv
// Turns the stepper coil-phase output into a one-cycle tick per newly energised phase.
module lid_step_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic       step_tick
);

  logic [3:0] phase_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase_prev <= 4'b0000;
    else
      phase_prev <= phase_in;
  end

  // An all-zero phase means the coils are off, so it is never a step.
  assign step_tick = (phase_in != phase_prev) && (phase_in != 4'b0000);

endmodule

// File: rtl/lid_motion_ctrl.sv
// Lid stepper sequencer: open/close/stop requests, step counting and end-stop handling.
// Optional step watchdog enabled by defining LID_STEP_TIMEOUT_EN.
module lid_motion_ctrl
  import lid_pkg::*;
#(
  parameter int OPEN_STEPS = 512,
  parameter int SLOW_ZONE  = 32
`ifdef LID_STEP_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        open_req,
  input  logic        close_req,
  input  logic        stop_req,
  input  logic [3:0]  phase_in,
  output logic        motor_en,
  output logic        motor_dir,
  output logic [1:0]  motor_mode,
  output logic [15:0] position,
  output logic        busy,
  output logic        at_open,
  output logic        at_closed,
  output logic        fault
);

  localparam logic [15:0] OPEN_POS = 16'(OPEN_STEPS);
  localparam logic [15:0] SLOW_POS = 16'(SLOW_ZONE);

  lid_state_t  state, state_next;
  logic [15:0] pos_next;
  logic        step_tick;
  logic        only_open, only_close;

  lid_step_detect u_step_detect (
    .clk       (clk),
    .rst       (rst),
    .phase_in  (phase_in),
    .step_tick (step_tick)
  );

  assign only_open  = open_req && !close_req && !stop_req;
  assign only_close = close_req && !open_req && !stop_req;

`ifdef LID_STEP_TIMEOUT_EN
  logic [23:0] timer, timer_next;
`endif

  always_comb begin
    state_next = state;
    pos_next   = position;
`ifdef LID_STEP_TIMEOUT_EN
    timer_next = '0;
`endif
    case (state)
      IDLE: begin
        if (only_open && position < OPEN_POS)
          state_next = OPENING;
        else if (only_close && position != 16'd0)
          state_next = CLOSING;
      end
      OPENING: begin
        if (step_tick && position < OPEN_POS)
          pos_next = position + 16'd1;
        // A reversal whose new target is already reached simply stops.
        if (stop_req)
          state_next = IDLE;
        else if (only_close)
          state_next = (pos_next != 16'd0) ? CLOSING : IDLE;
        else if (pos_next == OPEN_POS)
          state_next = IDLE;
      end
      CLOSING: begin
        if (step_tick && position != 16'd0)
          pos_next = position - 16'd1;
        if (stop_req)
          state_next = IDLE;
        else if (only_open)
          state_next = (pos_next != OPEN_POS) ? OPENING : IDLE;
        else if (pos_next == 16'd0)
          state_next = IDLE;
      end
      default: state_next = state;
    endcase
`ifdef LID_STEP_TIMEOUT_EN
    // The watchdog only runs while staying in the same moving state without a step.
    if (state_next == state && (state == OPENING || state == CLOSING) && !step_tick) begin
      if (timer == TIMEOUT_CYCLES - 24'd1)
        state_next = FAULT;
      else
        timer_next = timer + 24'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      position   <= '0;
      motor_en   <= 1'b0;
      motor_dir  <= DIR_OPEN;
      motor_mode <= MODE_FAST;
      busy       <= 1'b0;
      at_open    <= 1'b0;
      at_closed  <= 1'b1;
    end else begin
      state      <= state_next;
      position   <= pos_next;
      motor_en   <= (state_next == OPENING) || (state_next == CLOSING);
      motor_dir  <= (state_next == CLOSING) ? ~DIR_OPEN : DIR_OPEN;
      motor_mode <= speed_mode(state_next, pos_next, OPEN_POS, SLOW_POS);
      busy       <= (state_next == OPENING) || (state_next == CLOSING);
      at_open    <= (state_next == IDLE) && (pos_next == OPEN_POS);
      at_closed  <= (state_next == IDLE) && (pos_next == 16'd0);
    end
  end

`ifdef LID_STEP_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      fault <= 1'b0;
    end else begin
      timer <= timer_next;
      fault <= (state_next == FAULT);
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_lid_motion_ctrl.sv
// Directed self-checking bench for lid_motion_ctrl with an 8-step lid and 2-step slow zone.
module tb_lid_motion_ctrl;

  localparam int OPEN = 8;
  localparam int SLOW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        open_req, close_req, stop_req;
  logic [3:0]  phase_in;
  logic        motor_en, motor_dir, busy, at_open, at_closed, fault;
  logic [1:0]  motor_mode;
  logic [15:0] position;

  int tests_run    = 0;
  int tests_failed = 0;
  int phase_idx    = 3;

  always #5 clk = ~clk;

  lid_motion_ctrl #(
    .OPEN_STEPS (OPEN),
    .SLOW_ZONE  (SLOW)
`ifdef LID_STEP_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (24'd100)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .open_req   (open_req),
    .close_req  (close_req),
    .stop_req   (stop_req),
    .phase_in   (phase_in),
    .motor_en   (motor_en),
    .motor_dir  (motor_dir),
    .motor_mode (motor_mode),
    .position   (position),
    .busy       (busy),
    .at_open    (at_open),
    .at_closed  (at_closed),
    .fault      (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_phase();
    phase_idx = (phase_idx + 1) % 4;
    phase_in  = 4'b0001 << phase_idx;
  endtask

  task automatic step_once();
    next_phase();
    tick();
  endtask

  // One-cycle request pulse, optionally coinciding with a new coil phase.
  task automatic pulse(input logic o, input logic c, input logic s, input logic with_step);
    open_req  = o;
    close_req = c;
    stop_req  = s;
    if (with_step) next_phase();
    tick();
    open_req  = 1'b0;
    close_req = 1'b0;
    stop_req  = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (position !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_position got %0d expected 0", position); end
    tests_run++;
    if (at_closed !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_at_closed got %b expected 1", at_closed); end
    tests_run++;
    if (at_open !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_at_open got %b expected 0", at_open); end
    tests_run++;
    if (motor_en !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_en_busy got %b%b expected 00", motor_en, busy); end
    tests_run++;
    if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault got %b expected 0", fault); end
    tests_run++;
    if (motor_dir !== 1'b0 || motor_mode !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_dir_mode got %b/%b expected 0/00", motor_dir, motor_mode); end
  endtask

  task automatic test_full_open();
    logic [1:0] exp_mode;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (motor_en !== 1'b1 || motor_dir !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL open_start en/dir/busy got %b%b%b expected 101", motor_en, motor_dir, busy); end
    tests_run++;
    if (motor_mode !== 2'b00) begin tests_failed++; $display("[TB] FAIL open_start_mode got %b expected 00", motor_mode); end
    for (int i = 1; i <= OPEN; i++) begin
      step_once();
      tests_run++;
      if (position !== 16'(i)) begin tests_failed++; $display("[TB] FAIL open_pos step %0d got %0d expected %0d", i, position, i); end
      if (i < OPEN) begin
        exp_mode = ((OPEN - i) <= SLOW) ? 2'b01 : 2'b00;
        tests_run++;
        if (motor_en !== 1'b1 || motor_mode !== exp_mode) begin tests_failed++; $display("[TB] FAIL open_run step %0d en/mode got %b/%b expected 1/%b", i, motor_en, motor_mode, exp_mode); end
      end
    end
    tests_run++;
    if (motor_en !== 1'b0 || at_open !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL open_end en/at_open/busy got %b%b%b expected 010", motor_en, at_open, busy); end
    step_once();
    tests_run++;
    if (position !== 16'd8) begin tests_failed++; $display("[TB] FAIL idle_step_ignored got %0d expected 8", position); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (busy !== 1'b0 || motor_en !== 1'b0 || position !== 16'd8) begin tests_failed++; $display("[TB] FAIL open_at_target busy/en/pos got %b%b/%0d expected 00/8", busy, motor_en, position); end
  endtask

  task automatic test_full_close();
    logic [1:0] exp_mode;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (motor_en !== 1'b1 || motor_dir !== 1'b1 || motor_mode !== 2'b00) begin tests_failed++; $display("[TB] FAIL close_start en/dir/mode got %b%b/%b expected 11/00", motor_en, motor_dir, motor_mode); end
    for (int i = 1; i <= OPEN; i++) begin
      step_once();
      tests_run++;
      if (position !== 16'(OPEN - i)) begin tests_failed++; $display("[TB] FAIL close_pos step %0d got %0d expected %0d", i, position, OPEN - i); end
      if (i < OPEN) begin
        exp_mode = ((OPEN - i) <= SLOW) ? 2'b01 : 2'b00;
        tests_run++;
        if (motor_mode !== exp_mode) begin tests_failed++; $display("[TB] FAIL close_mode step %0d got %b expected %b", i, motor_mode, exp_mode); end
      end
    end
    tests_run++;
    if (motor_en !== 1'b0 || at_closed !== 1'b1) begin tests_failed++; $display("[TB] FAIL close_end en/at_closed got %b%b expected 01", motor_en, at_closed); end
  endtask

  task automatic test_reversal();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step_once();
    tests_run++;
    if (position !== 16'd3) begin tests_failed++; $display("[TB] FAIL rev_pos_before got %0d expected 3", position); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (motor_dir !== 1'b1 || motor_en !== 1'b1 || position !== 16'd3) begin tests_failed++; $display("[TB] FAIL rev_flip dir/en/pos got %b%b/%0d expected 11/3", motor_dir, motor_en, position); end
    repeat (3) step_once();
    tests_run++;
    if (position !== 16'd0 || at_closed !== 1'b1 || motor_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rev_end pos/at_closed/en got %0d/%b%b expected 0/10", position, at_closed, motor_en); end
  endtask

  task automatic test_back_to_back();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step_once();
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (position !== 16'd3 || motor_dir !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL coincident_step pos/dir/busy got %0d/%b%b expected 3/11", position, motor_dir, busy); end
    repeat (3) step_once();
    tests_run++;
    if (position !== 16'd0 || at_closed !== 1'b1) begin tests_failed++; $display("[TB] FAIL coincident_end pos/at_closed got %0d/%b expected 0/1", position, at_closed); end
  endtask

  task automatic test_stop_conflict();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step_once();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (motor_en !== 1'b0 || busy !== 1'b0 || position !== 16'd4) begin tests_failed++; $display("[TB] FAIL stop en/busy/pos got %b%b/%0d expected 00/4", motor_en, busy, position); end
    tests_run++;
    if (at_open !== 1'b0 || at_closed !== 1'b0) begin tests_failed++; $display("[TB] FAIL stop_mid_flags got %b%b expected 00", at_open, at_closed); end
    step_once();
    tests_run++;
    if (position !== 16'd4) begin tests_failed++; $display("[TB] FAIL stop_hold got %0d expected 4", position); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (busy !== 1'b0 || position !== 16'd4) begin tests_failed++; $display("[TB] FAIL open_close_conflict busy/pos got %b/%0d expected 0/4", busy, position); end
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL stop_priority busy got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step_once();
    tests_run++;
    if (position !== 16'd5 || motor_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset pos/en got %0d/%b expected 5/1", position, motor_en); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (motor_en !== 1'b0 || position !== 16'd0 || at_closed !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_reset en/pos/at_closed got %b/%0d/%b expected 0/0/1", motor_en, position, at_closed); end
    rst = 1'b0;
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (busy !== 1'b0 || position !== 16'd0) begin tests_failed++; $display("[TB] FAIL close_at_closed busy/pos got %b/%0d expected 0/0", busy, position); end
  endtask

`ifdef LID_STEP_TIMEOUT_EN
  task automatic test_timeout();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (99) tick();
    tests_run++;
    if (fault !== 1'b0 || motor_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_early fault/en got %b%b expected 01", fault, motor_en); end
    tick();
    tests_run++;
    if (fault !== 1'b1 || motor_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_hit fault/en got %b%b expected 10", fault, motor_en); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (fault !== 1'b1 || busy !== 1'b0 || motor_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL fault_sticky fault/busy/en got %b%b%b expected 100", fault, busy, motor_en); end
  endtask
`endif

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit expired");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst       = 1'b1;
    open_req  = 1'b0;
    close_req = 1'b0;
    stop_req  = 1'b0;
    phase_in  = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_full_open();
    test_full_close();
    test_reversal();
    test_back_to_back();
    test_stop_conflict();
    test_mid_reset();
`ifdef LID_STEP_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lid_motion_ctrl.md
Name: lid_motion_ctrl

Overview:
Sequencer for the lid stepper path. Accepts open/close/stop requests, drives the step interface's direction, enable and speed-mode inputs, and counts completed steps by watching its 4-bit coil-phase output. Tracks lid position in steps between 0 (closed) and OPEN_STEPS (open), and stops the motor at either end. Sits between the toybox top-level FSM and the lid stepper interface.

Parameters:
OPEN_STEPS, 512, steps from fully closed to fully open; position range 0..OPEN_STEPS
SLOW_ZONE, 32, steps before either end limit where the slow speed mode is requested
DIR_OPEN, 1'b0, value on motor_dir that moves the lid toward open; closing uses ~DIR_OPEN
MODE_FAST, 2'b00, speed mode used outside the slow zone
MODE_SLOW, 2'b01, speed mode used inside the slow zone
TIMEOUT_CYCLES, 24'd6000000, clk cycles allowed between steps while moving (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
open_req  in  1  one-cycle pulse: move to fully open
close_req  in  1  one-cycle pulse: move to fully closed
stop_req  in  1  one-cycle pulse: halt at current position
phase_in  in  4  coil phase from the stepper interface (one-hot or 0000)
motor_en  out  1  enable to the stepper interface
motor_dir  out  1  direction to the stepper interface
motor_mode  out  2  speed mode to the stepper interface
position  out  16  current lid position in steps
busy  out  1  high in OPENING or CLOSING
at_open  out  1  high when position == OPEN_STEPS and idle
at_closed  out  1  high when position == 0 and idle
fault  out  1  sticky watchdog fault (optional feature only, else tied 0)

Behaviour:
- Reset values: state IDLE, position 0, motor_en 0, motor_dir DIR_OPEN, motor_mode MODE_FAST, busy 0, fault 0, phase_prev 0000. at_closed is 1 after reset and at_open is 0.
- Step detection: register phase_in into phase_prev each clk. step_tick = (phase_in != phase_prev) && (phase_in != 0), so exactly one tick per new phase. The enable-up transition from 0000 to a first phase counts as a step.
- States: IDLE, OPENING, CLOSING, and FAULT (the last only with the optional feature).
- IDLE: open_req with position < OPEN_STEPS goes to OPENING. close_req with position > 0 goes to CLOSING. A request already at its target is ignored.
- OPENING: motor_en=1, motor_dir=DIR_OPEN. On step_tick, position +1. When the increment reaches OPEN_STEPS, go to IDLE and drop motor_en in the same cycle.
- CLOSING: motor_en=1, motor_dir=~DIR_OPEN. On step_tick, position -1. When the decrement reaches 0, go to IDLE.
- Reversal: close_req in OPENING goes directly to CLOSING, and open_req in CLOSING goes directly to OPENING. Direction flips on the next cycle and en stays high.
- stop_req in any moving state goes to IDLE, with motor_en=0 on the next cycle.
- Request priority in the same cycle: stop_req wins over everything. open_req and close_req together with no stop_req are ignored.
- A step_tick that coincides with a transition is still counted, in the direction of the current state.
- Position saturates: it never exceeds OPEN_STEPS and never goes below 0.
- step_tick in IDLE does not change position (coast-down phases are ignored).
- Speed mode: when moving, motor_mode=MODE_SLOW if the distance to the target is ≤ SLOW_ZONE, else MODE_FAST. The distance is OPEN_STEPS-position when opening and position when closing. In IDLE, motor_mode=MODE_FAST.
- Outputs are registered, so there is one cycle of latency from request to motor_en.
- Reset mid-motion stops the motor immediately and sets position to 0. The top-level FSM must re-home the lid by issuing close_req.

Optional Feature:
Macro LID_STEP_TIMEOUT_EN.
- With the macro: a 24-bit counter clears on every step_tick and on entry to a moving state, and increments while OPENING or CLOSING. Reaching TIMEOUT_CYCLES enters FAULT: motor_en=0 and fault=1. FAULT is left only by rst; all requests are ignored.
- Without the macro: no counter and no FAULT state, and fault is tied to 0.

Decomposition:
- Shared package lid_pkg holds the state encoding localparams (IDLE, OPENING, CLOSING, FAULT), the MODE_FAST and MODE_SLOW codes, and DIR_OPEN, so the top-level FSM and the other lid controller use the same values.
- One sub-module, lid_step_detect, holds phase_prev and step_tick so it can be reused for the second lid.
- Position and state logic stay in lid_motion_ctrl.

Test Plan:
- Reset: rst high, then low → position=0, at_closed=1, motor_en=0, busy=0.
- Full open: OPEN_STEPS=8, SLOW_ZONE=2, open_req, model drives 8 phase changes → motor_en=1 one cycle after the request, motor_dir=0, motor_mode=01 once position ≥6, position=8, at_open=1, motor_en=0 after the 8th tick.
- Reversal: open_req, 3 ticks, close_req → motor_dir=1 next cycle, motor_en stays 1; 3 more ticks give position=0, at_closed=1.
- Stop and conflicts: stop_req at position 4 → IDLE, position holds 4. open_req and close_req together → no change. open_req when at_open=1 → ignored.
- Mid-motion reset: rst during OPENING at position 5 → motor_en=0 immediately, position=0.
- Timeout (with LID_STEP_TIMEOUT_EN, TIMEOUT_CYCLES=100): open_req with phase_in frozen → fault=1 and motor_en=0 at cycle 100; a later open_req is ignored.
